// File: rtl/axi_lite_reg_slave_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes,
// FSM state encodings and the width of the in-slot register offset.
package axi_lite_reg_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Address bits below this index select a register inside a slot;
  // the bits above it select the slot.
  localparam int SLOT_OFFSET_W = 8;

  typedef enum logic [2:0] {
    W_IDLE   = 3'd0,
    W_WAIT_W = 3'd1,
    W_WAIT_A = 3'd2,
    W_EXEC   = 3'd3,
    W_RESP   = 3'd4
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_EXEC = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave front-end. Each accepted write or read becomes a single
// cycle strobe (reg_wren / reg_rden) with registered address, data and byte
// strobes for the register blocks behind it. Slots at or above C_NUM_SLOTS
// get SLVERR and never produce a strobe.
module axi_lite_reg_slave
  import axi_lite_reg_slave_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_NUM_SLOTS        = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     reg_awaddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   reg_wstrb,
  output logic                              reg_wren,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     reg_araddr,
  output logic                              reg_rden,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     reg_rdata
);

  localparam int SLOT_W = C_S_AXI_ADDR_WIDTH - SLOT_OFFSET_W;

  // True when the slot field of the address names a populated slot.
  function automatic logic slot_valid(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
    logic [SLOT_W-1:0] slot;
    slot = addr[C_S_AXI_ADDR_WIDTH-1:SLOT_OFFSET_W];
    return 32'(slot) < $unsigned(C_NUM_SLOTS);
  endfunction

  logic     ready_en;
  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;
  logic     aw_hs, w_hs, ar_hs;
  logic     aw_slot_ok, ar_slot_ok;

  assign aw_hs      = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs       = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs      = S_AXI_ARVALID & S_AXI_ARREADY;
  assign aw_slot_ok = slot_valid(reg_awaddr);
  assign ar_slot_ok = slot_valid(reg_araddr);

  // Hold all ready outputs low until the first clock edge after reset release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) ready_en <= 1'b0;
    else                ready_en <= 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) w_state <= W_IDLE;
    else                w_state <= w_state_nxt;
  end

  // Write FSM next state and handshake/strobe outputs; AW and W may arrive in either order.
  always_comb begin
    w_state_nxt   = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    reg_wren      = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = ready_en;
        S_AXI_WREADY  = ready_en;
        if (ready_en) begin
          if (S_AXI_AWVALID && S_AXI_WVALID) w_state_nxt = W_EXEC;
          else if (S_AXI_AWVALID)            w_state_nxt = W_WAIT_W;
          else if (S_AXI_WVALID)             w_state_nxt = W_WAIT_A;
        end
      end
      W_WAIT_W: begin
        S_AXI_WREADY = ready_en;
        if (ready_en && S_AXI_WVALID) w_state_nxt = W_EXEC;
      end
      W_WAIT_A: begin
        S_AXI_AWREADY = ready_en;
        if (ready_en && S_AXI_AWVALID) w_state_nxt = W_EXEC;
      end
      W_EXEC: begin
        reg_wren    = aw_slot_ok;
        w_state_nxt = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Latch write address/data/strobes on their own handshakes and the response in the execute cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      reg_awaddr  <= '0;
      reg_wdata   <= '0;
      reg_wstrb   <= '0;
      S_AXI_BRESP <= RESP_OKAY;
    end else begin
      if (aw_hs) reg_awaddr <= S_AXI_AWADDR;
      if (w_hs) begin
        reg_wdata <= S_AXI_WDATA;
        reg_wstrb <= S_AXI_WSTRB;
      end
      if (w_state == W_EXEC) S_AXI_BRESP <= aw_slot_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read FSM state register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= R_IDLE;
    else                r_state <= r_state_nxt;
  end

  // Read FSM next state and handshake/strobe outputs.
  always_comb begin
    r_state_nxt   = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    reg_rden      = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = ready_en;
        if (ready_en && S_AXI_ARVALID) r_state_nxt = R_EXEC;
      end
      R_EXEC: begin
        reg_rden    = ar_slot_ok;
        r_state_nxt = R_RESP;
      end
      R_RESP: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Latch the read address and capture the register mux output in the execute cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      reg_araddr  <= '0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else begin
      if (ar_hs) reg_araddr <= S_AXI_ARADDR;
      if (r_state == R_EXEC) begin
        S_AXI_RDATA <= ar_slot_ok ? reg_rdata : '0;
        S_AXI_RRESP <= ar_slot_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: directed latency/reset cases
// plus randomized traffic checked against a word-array register model.
module tb_axi_lite_reg_slave;

  localparam int NSLOTS = 4;

  logic        S_AXI_ACLK = 1'b0;
  logic        S_AXI_ARESETN = 1'b0;
  logic [11:0] S_AXI_AWADDR = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [11:0] S_AXI_ARADDR = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [11:0] reg_awaddr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_wren;
  logic [11:0] reg_araddr;
  logic        reg_rden;
  logic [31:0] reg_rdata;

  int checks = 0;
  int errors = 0;
  int wren_count = 0;
  int rden_count = 0;

  logic [31:0] dmem   [256] = '{default: 32'h0};
  logic [31:0] shadow [256] = '{default: 32'h0};

  axi_lite_reg_slave dut (
    .S_AXI_ACLK   (S_AXI_ACLK),
    .S_AXI_ARESETN(S_AXI_ARESETN),
    .S_AXI_AWADDR (S_AXI_AWADDR),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA  (S_AXI_WDATA),
    .S_AXI_WSTRB  (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BRESP  (S_AXI_BRESP),
    .S_AXI_BVALID (S_AXI_BVALID),
    .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA  (S_AXI_RDATA),
    .S_AXI_RRESP  (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY),
    .reg_awaddr   (reg_awaddr),
    .reg_wdata    (reg_wdata),
    .reg_wstrb    (reg_wstrb),
    .reg_wren     (reg_wren),
    .reg_araddr   (reg_araddr),
    .reg_rden     (reg_rden),
    .reg_rdata    (reg_rdata)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  // Downstream register block stand-in: byte-masked word store, combinational read.
  always @(posedge S_AXI_ACLK) begin
    if (reg_wren)
      for (int b = 0; b < 4; b++)
        if (reg_wstrb[b]) dmem[reg_araddr_idx(reg_awaddr)][8*b +: 8] <= reg_wdata[8*b +: 8];
  end
  assign reg_rdata = dmem[reg_araddr_idx(reg_araddr)];

  // Count strobe pulses so each transaction can verify exactly one (or zero) strobe.
  always @(posedge S_AXI_ACLK) begin
    if (reg_wren) wren_count <= wren_count + 1;
    if (reg_rden) rden_count <= rden_count + 1;
  end

  function automatic int reg_araddr_idx(input logic [11:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic bit slot_ok(input logic [11:0] a);
    return int'(a[11:8]) < NSLOTS;
  endfunction

  function automatic logic [31:0] expRead(input logic [11:0] a);
    return slot_ok(a) ? shadow[reg_araddr_idx(a)] : 32'h0;
  endfunction

  task automatic modelWrite(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    if (slot_ok(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) shadow[reg_araddr_idx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Full write transaction with independent AW/W start delays and a B back-pressure delay.
  task automatic axiWrite(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly);
    int w0;
    int t;
    logic [1:0] exp_resp;
    w0 = wren_count;
    exp_resp = slot_ok(a) ? 2'b00 : 2'b10;
    fork
      begin
        int ta;
        ta = 0;
        repeat (aw_dly) @(negedge S_AXI_ACLK);
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        while (!S_AXI_AWREADY && ta < 50) begin @(negedge S_AXI_ACLK); ta++; end
        if (ta >= 50) checkOutput("aw_handshake_timeout", 32'(ta), 32'd0);
        @(negedge S_AXI_ACLK);
        S_AXI_AWVALID = 1'b0;
      end
      begin
        int tw;
        tw = 0;
        repeat (w_dly) @(negedge S_AXI_ACLK);
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        while (!S_AXI_WREADY && tw < 50) begin @(negedge S_AXI_ACLK); tw++; end
        if (tw >= 50) checkOutput("w_handshake_timeout", 32'(tw), 32'd0);
        @(negedge S_AXI_ACLK);
        S_AXI_WVALID = 1'b0;
      end
    join
    t = 0;
    while (!S_AXI_BVALID && t < 50) begin @(negedge S_AXI_ACLK); t++; end
    checkOutput("bvalid_seen", 32'(S_AXI_BVALID), 32'd1);
    repeat (b_dly) begin
      @(negedge S_AXI_ACLK);
      checkOutput("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
    end
    checkOutput("bresp", 32'(S_AXI_BRESP), 32'(exp_resp));
    S_AXI_BREADY = 1'b1;
    @(negedge S_AXI_ACLK);
    S_AXI_BREADY = 1'b0;
    checkOutput("wren_pulses", 32'(wren_count - w0), slot_ok(a) ? 32'd1 : 32'd0);
    modelWrite(a, d, s);
  endtask

  // Full read transaction with an AR start delay and an R back-pressure delay.
  task automatic axiRead(input logic [11:0] a, input int ar_dly, input int r_dly);
    int r0;
    int t;
    logic [31:0] exp_data;
    r0 = rden_count;
    t = 0;
    repeat (ar_dly) @(negedge S_AXI_ACLK);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && t < 50) begin @(negedge S_AXI_ACLK); t++; end
    if (t >= 50) checkOutput("ar_handshake_timeout", 32'(t), 32'd0);
    exp_data = expRead(a);
    @(negedge S_AXI_ACLK);
    S_AXI_ARVALID = 1'b0;
    t = 0;
    while (!S_AXI_RVALID && t < 50) begin @(negedge S_AXI_ACLK); t++; end
    checkOutput("rvalid_seen", 32'(S_AXI_RVALID), 32'd1);
    repeat (r_dly) begin
      @(negedge S_AXI_ACLK);
      checkOutput("rdata_hold", S_AXI_RDATA, exp_data);
    end
    checkOutput("rdata", S_AXI_RDATA, exp_data);
    checkOutput("rresp", 32'(S_AXI_RRESP), slot_ok(a) ? 32'd0 : 32'd2);
    S_AXI_RREADY = 1'b1;
    @(negedge S_AXI_ACLK);
    S_AXI_RREADY = 1'b0;
    checkOutput("rden_pulses", 32'(rden_count - r0), slot_ok(a) ? 32'd1 : 32'd0);
  endtask

  // Randomized mix of writes, reads and overlapping write+read to different registers.
  task automatic applyStimulus(input int n);
    logic [11:0] a1, a2;
    for (int i = 0; i < n; i++) begin
      int op;
      a1 = {4'($urandom_range(0, 5)), 6'($urandom_range(0, 63)), 2'b00};
      a2 = {4'($urandom_range(0, 5)), 6'($urandom_range(0, 63)), 2'b00};
      if (a2[9:2] == a1[9:2]) a2[2] = ~a2[2];
      op = $urandom_range(0, 2);
      if (op == 0)
        axiWrite(a1, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else if (op == 1)
        axiRead(a1, $urandom_range(0, 3), $urandom_range(0, 3));
      else
        fork
          axiWrite(a1, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
          axiRead(a2, $urandom_range(0, 3), $urandom_range(0, 3));
        join
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0;
    $display("[TB] starting");
    // Reset state and ready release timing.
    repeat (3) @(negedge S_AXI_ACLK);
    checkOutput("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    checkOutput("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    checkOutput("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
    checkOutput("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
    checkOutput("rst_wren",    32'(reg_wren),      32'd0);
    checkOutput("rst_awaddr",  32'(reg_awaddr),    32'd0);
    checkOutput("rst_rdata",   S_AXI_RDATA,        32'd0);
    S_AXI_ARESETN = 1'b1;
    #1;
    checkOutput("rel_wready_first", 32'(S_AXI_WREADY), 32'd0);
    @(negedge S_AXI_ACLK);
    checkOutput("rel_wready_next", 32'(S_AXI_WREADY), 32'd1);
    checkOutput("rel_arready_next", 32'(S_AXI_ARREADY), 32'd1);
    checkOutput("rel_bvalid", 32'(S_AXI_BVALID), 32'd0);

    // AW+W together with BREADY already high: strobe at N+1, BVALID at N+2.
    S_AXI_BREADY = 1'b1;
    S_AXI_AWADDR = 12'h004; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hA5A5_0001; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    checkOutput("t2_awready", 32'(S_AXI_AWREADY), 32'd1);
    @(negedge S_AXI_ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    checkOutput("t2_wren", 32'(reg_wren), 32'd1);
    checkOutput("t2_awaddr", 32'(reg_awaddr), 32'h004);
    checkOutput("t2_wdata", reg_wdata, 32'hA5A5_0001);
    checkOutput("t2_bvalid_early", 32'(S_AXI_BVALID), 32'd0);
    @(negedge S_AXI_ACLK);
    checkOutput("t2_wren_off", 32'(reg_wren), 32'd0);
    checkOutput("t2_bvalid", 32'(S_AXI_BVALID), 32'd1);
    checkOutput("t2_bresp", 32'(S_AXI_BRESP), 32'd0);
    @(negedge S_AXI_ACLK);
    S_AXI_BREADY = 1'b0;
    checkOutput("t2_bvalid_done", 32'(S_AXI_BVALID), 32'd0);
    modelWrite(12'h004, 32'hA5A5_0001, 4'hF);

    // W two cycles ahead of AW, then B held off for 5 cycles.
    w0 = wren_count;
    S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge S_AXI_ACLK);
    S_AXI_WVALID = 1'b0;
    checkOutput("t3_wready_wait_a", 32'(S_AXI_WREADY), 32'd0);
    @(negedge S_AXI_ACLK);
    S_AXI_AWADDR = 12'h008; S_AXI_AWVALID = 1'b1;
    checkOutput("t3_awready", 32'(S_AXI_AWREADY), 32'd1);
    @(negedge S_AXI_ACLK);
    S_AXI_AWVALID = 1'b0;
    checkOutput("t3_wren", 32'(reg_wren), 32'd1);
    @(negedge S_AXI_ACLK);
    for (int k = 0; k < 5; k++) begin
      checkOutput("t3_bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
      checkOutput("t3_bresp_hold", 32'(S_AXI_BRESP), 32'd0);
      checkOutput("t3_awready_blocked", 32'(S_AXI_AWREADY | S_AXI_WREADY), 32'd0);
      @(negedge S_AXI_ACLK);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge S_AXI_ACLK);
    S_AXI_BREADY = 1'b0;
    checkOutput("t3_single_wren", 32'(wren_count - w0), 32'd1);
    modelWrite(12'h008, 32'h0BAD_F00D, 4'hF);

    // Read of 0x010 holding 0x12345678 with RREADY low for 3 cycles.
    axiWrite(12'h010, 32'h1234_5678, 4'hF, 0, 0, 0);
    S_AXI_ARADDR = 12'h010; S_AXI_ARVALID = 1'b1;
    checkOutput("t4_arready", 32'(S_AXI_ARREADY), 32'd1);
    @(negedge S_AXI_ACLK);
    S_AXI_ARVALID = 1'b0;
    checkOutput("t4_rden", 32'(reg_rden), 32'd1);
    checkOutput("t4_araddr", 32'(reg_araddr), 32'h010);
    checkOutput("t4_rvalid_early", 32'(S_AXI_RVALID), 32'd0);
    @(negedge S_AXI_ACLK);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t4_rvalid", 32'(S_AXI_RVALID), 32'd1);
      checkOutput("t4_rdata", S_AXI_RDATA, 32'h1234_5678);
      checkOutput("t4_rresp", 32'(S_AXI_RRESP), 32'd0);
      checkOutput("t4_rden_once", 32'(reg_rden), 32'd0);
      @(negedge S_AXI_ACLK);
    end
    S_AXI_RREADY = 1'b1;
    @(negedge S_AXI_ACLK);
    S_AXI_RREADY = 1'b0;
    checkOutput("t4_rvalid_done", 32'(S_AXI_RVALID), 32'd0);

    // Unpopulated slot 15: SLVERR, no strobes, zero read data.
    axiWrite(12'h300, 32'hDEAD_BEEF, 4'hF, 0, 1, 0);
    axiWrite(12'hF00, 32'hCAFE_CAFE, 4'hF, 1, 0, 2);
    axiRead(12'hF00, 0, 1);
    axiRead(12'h300, 0, 0);

    // Reset while the write waits for W and the read sits in its response phase.
    S_AXI_AWADDR = 12'h020; S_AXI_AWVALID = 1'b1;
    S_AXI_ARADDR = 12'h010; S_AXI_ARVALID = 1'b1;
    @(negedge S_AXI_ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    checkOutput("t6_wait_w", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'b01);
    @(negedge S_AXI_ACLK);
    checkOutput("t6_rvalid_pre", 32'(S_AXI_RVALID), 32'd1);
    w0 = wren_count;
    S_AXI_ARESETN = 1'b0;
    #1;
    checkOutput("t6_rvalid_drop", 32'(S_AXI_RVALID), 32'd0);
    checkOutput("t6_bvalid_drop", 32'(S_AXI_BVALID), 32'd0);
    checkOutput("t6_ready_drop", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
    checkOutput("t6_rdata_clear", S_AXI_RDATA, 32'd0);
    repeat (2) @(negedge S_AXI_ACLK);
    S_AXI_ARESETN = 1'b1;
    repeat (3) @(negedge S_AXI_ACLK);
    checkOutput("t6_no_wren", 32'(wren_count - w0), 32'd0);
    checkOutput("t6_rvalid_idle", 32'(S_AXI_RVALID), 32'd0);
    axiWrite(12'h020, 32'h5555_AAAA, 4'h5, 0, 0, 1);
    axiRead(12'h020, 0, 0);

    // Randomized traffic against the register model.
    applyStimulus(60);

    repeat (2) @(negedge S_AXI_ACLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
- AXI4-Lite slave front-end for the peripheral register space.
- Terminates the five AXI channels and converts each accepted transaction into a single-cycle strobe, with registered address, data and strobes, for the register blocks behind it (SPI register file and siblings).
- Returns read data from the register block's combinational read mux.
- Generates OKAY/SLVERR responses based on a slot decode of the address.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: AXI data width, also register width.
- C_S_AXI_ADDR_WIDTH, 12: AXI address width; bits [7:0] are the register offset, bits [ADDR_WIDTH-1:8] are the slot.
- C_NUM_SLOTS, 4: slots 0..C_NUM_SLOTS-1 are populated; any higher slot returns SLVERR.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low; clock S_AXI_ACLK.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  AW handshake.
- S_AXI_WDATA  in  DATA_WIDTH / S_AXI_WSTRB  in  DATA_WIDTH/8  write data and byte strobes.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  W handshake.
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response.
- S_AXI_ARADDR  in  ADDR_WIDTH / S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read address.
- S_AXI_RDATA  out  DATA_WIDTH / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data.
- reg_awaddr  out  ADDR_WIDTH  latched write address.
- reg_wdata  out  DATA_WIDTH  latched write data.
- reg_wstrb  out  DATA_WIDTH/8  latched byte strobes.
- reg_wren  out  1  one-cycle write strobe.
- reg_araddr  out  ADDR_WIDTH  latched read address.
- reg_rden  out  1  one-cycle read strobe.
- reg_rdata  in  DATA_WIDTH  combinational read data from the register block, valid in the reg_rden cycle.

Behaviour:
- Reset (asynchronous, while ARESETN=0):
  - All outputs are 0; both FSMs go to IDLE; any in-flight transaction is discarded.
  - No strobe is issued during or after reset for a discarded transaction.
  - A ready_en flag is 0 during reset and sets on the first clock edge after deassert; AWREADY, WREADY and ARREADY are all gated by ready_en.
- Write FSM, states W_IDLE, W_WAIT_W, W_WAIT_A, W_EXEC, W_RESP:
  - AWREADY = ready_en & (W_IDLE | W_WAIT_A).
  - WREADY = ready_en & (W_IDLE | W_WAIT_W).
  - W_IDLE: AW and W together -> W_EXEC; AW only -> W_WAIT_W; W only -> W_WAIT_A. The address, data and strobes are latched on their own handshakes.
  - W_WAIT_W: W handshake -> W_EXEC. W_WAIT_A: AW handshake -> W_EXEC.
  - W_EXEC (one cycle): reg_wren=1 only if slot < C_NUM_SLOTS; BRESP is latched as OKAY (2'b00) or SLVERR (2'b10); next state W_RESP.
  - W_RESP: BVALID=1, BRESP held stable; on BREADY -> W_IDLE.
  - Latency: handshake completing at edge N gives reg_wren high in cycle N+1 and BVALID from cycle N+2. BREADY already high means 3 cycles per write.
  - No new AW or W is accepted until the B handshake completes (one outstanding write).
- Read FSM, states R_IDLE, R_EXEC, R_RESP:
  - ARREADY = ready_en & R_IDLE; the AR handshake latches reg_araddr -> R_EXEC.
  - R_EXEC (one cycle): reg_rden=1 if slot valid. RDATA is captured from reg_rdata, or 0 with SLVERR for an invalid slot. Next state R_RESP.
  - R_RESP: RVALID=1; RDATA and RRESP are held stable until RREADY -> R_IDLE.
  - Latency: AR at edge N gives reg_rden in N+1 and RVALID from N+2.
- Read and write channels run independently and may be active in the same cycle.
  - If reg_wren and reg_rden coincide on the same register, the read returns the pre-write value. The register updates at the edge and the read is captured at that same edge.
- reg_awaddr, reg_wdata and reg_wstrb hold their values after the strobe until the next accept. Byte-lane masking using WSTRB is done by the downstream register block.
- AWADDR/ARADDR bits [1:0] are passed through unchanged; no alignment check is made.

Decomposition:
- Shared package holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Write/read FSM state encodings.
  - Slot offset width constant (8).
- Single module with separate write and read always blocks; no sub-module.

Test Plan:
- Reset release: ARESETN 0->1 -> ready signals 0 in the first post-reset cycle and 1 from the next; BVALID/RVALID 0 throughout.
- AW+W together, addr 0x004, data 0xA5A5_0001, strb 0xF -> reg_wren one cycle at N+1 with reg_awaddr=0x004, reg_wdata=0xA5A5_0001; BVALID at N+2, BRESP=00.
- W two cycles before AW, then BREADY held low 5 cycles -> single reg_wren; BVALID stays high and BRESP stable; AWREADY/WREADY stay 0 until B completes.
- Read addr 0x010 with reg_rdata=0x1234_5678 and RREADY low 3 cycles -> reg_rden one cycle; RDATA=0x1234_5678, RRESP=00 held for 3 cycles.
- Write and read to addr 0xF00 (slot 15) -> no wren/rden; BRESP=10; RRESP=10 with RDATA=0.
- ARESETN asserted during W_WAIT_W and during R_RESP -> VALIDs drop immediately; no reg_wren after release; next transaction completes normally.
